// File: rtl/rom_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rom_load_ctrl: loader byte stream -> preamble capture + SDRAM word writes  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module rom_load_ctrl #(
  parameter int HDR_BYTES  = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 2097152
) (
  input  logic        wclk,
  input  logic        resetn,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        src_loading,
  input  logic        src_fail,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [7:0]  map_ctrl,
  output logic [3:0]  rom_size,
  output logic [23:0] rom_mask,
  output logic [23:0] ram_mask,
  output logic        loading,
  output logic        done,
  output logic        fail
);

  localparam int c_cw = $clog2(HDR_BYTES);
  localparam int c_pw = $clog2(FIFO_DEPTH);
  localparam int c_ww = $clog2(MAX_WORDS) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(HDR_BYTES - 1);
  localparam logic [c_ww-1:0] c_maxw = c_ww'(MAX_WORDS);
  localparam logic [c_pw:0]   c_full = (c_pw + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_DRAIN, S_DONE, S_FAIL
  } state_t;

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic [7:0]        r_map;
  logic [3:0]        r_rom_size;
  logic [7:0]        r_ram_size;
  logic [23:0]       r_rom_mask;
  logic [23:0]       r_ram_mask;
  logic [7:0]        r_lo;
  logic              r_toggle;
  logic [c_ww-1:0]   r_words;
  logic [15:0]       r_fifo_d [FIFO_DEPTH];
  logic [1:0]        r_fifo_s [FIFO_DEPTH];
  logic [c_pw-1:0]   r_wp;
  logic [c_pw-1:0]   r_rp;
  logic [c_pw:0]     r_count;
  logic              r_req;
  logic [21:0]       r_addr;
  logic [15:0]       r_din;
  logic [1:0]        r_ds;
  logic              r_loading;
  logic              r_done;
  logic              r_fail;

  logic              w_push;
  logic [15:0]       w_push_d;
  logic [1:0]        w_push_s;
  logic              w_active;
  logic              w_pop;
  logic              w_err;
  logic              w_wr;

  // Size code n selects a 1 KB << n window; codes of 14 and up cover the whole 24-bit space.
  function automatic logic [23:0] f_mask(input logic [7:0] sz, input logic zero_is_none);
    logic [23:0] m;
    if (zero_is_none && sz == 8'd0)
      m = 24'h000000;
    else if (sz >= 8'd14)
      m = 24'hFFFFFF;
    else
      m = (24'h000400 << sz[3:0]) - 24'd1;
    return m;
  endfunction

  always_comb begin
    w_push   = 1'b0;
    w_push_d = {din, r_lo};
    w_push_s = 2'b11;
    if (r_state == S_PAYLOAD && din_valid && r_toggle) begin
      w_push = 1'b1;
    end else if (r_state == S_DRAIN && r_toggle) begin
      w_push   = 1'b1;
      w_push_d = {8'h00, r_lo};
      w_push_s = 2'b01;
    end
    w_active = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
    w_pop    = r_req && mem_ack;
    // A full FIFO overflows even if the head is popped in the same cycle.
    w_err    = w_active && (src_fail || (w_push && (r_count == c_full || r_words == c_maxw)));
    w_wr     = w_push && !w_err;
  end

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_map      <= '0;
      r_rom_size <= '0;
      r_ram_size <= '0;
      r_rom_mask <= '0;
      r_ram_mask <= '0;
      r_lo       <= '0;
      r_toggle   <= 1'b0;
      r_words    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_ds       <= '0;
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_fifo_d[r_wp] <= w_push_d;
        r_fifo_s[r_wp] <= w_push_s;
        r_wp           <= r_wp + c_pw'(1);
        r_words        <= r_words + c_ww'(1);
      end
      if (w_pop) begin
        r_rp   <= r_rp + c_pw'(1);
        r_req  <= 1'b0;
        r_addr <= r_addr + 22'd1;
      end else if (!r_req && r_count != '0 && (r_state == S_PAYLOAD || r_state == S_DRAIN)) begin
        r_req <= 1'b1;
        r_din <= r_fifo_d[r_rp];
        r_ds  <= r_fifo_s[r_rp];
      end
      r_count <= r_count + (c_pw + 1)'(w_wr) - (c_pw + 1)'(w_pop);

      if (w_err) begin
        r_state   <= S_FAIL;
        r_loading <= 1'b0;
        r_fail    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (din_valid) begin
              r_state   <= S_HEADER;
              r_cnt     <= c_cw'(1);
              r_loading <= 1'b1;
            end
          end
          S_HEADER: begin
            if (din_valid) begin
              r_cnt <= r_cnt + c_cw'(1);
              if (r_cnt == c_cw'(21)) r_map      <= din;
              if (r_cnt == c_cw'(23)) r_rom_size <= din[3:0];
              if (r_cnt == c_cw'(24)) r_ram_size <= din;
            end
            if (din_valid && r_cnt == c_last) begin
              r_rom_mask <= f_mask({4'h0, r_rom_size}, 1'b0);
              r_ram_mask <= f_mask(r_ram_size, 1'b1);
              r_toggle   <= 1'b0;
              r_addr     <= '0;
              r_words    <= '0;
              r_state    <= S_PAYLOAD;
            end else if (!src_loading) begin
              r_state   <= S_FAIL;
              r_loading <= 1'b0;
              r_fail    <= 1'b1;
            end
          end
          S_PAYLOAD: begin
            if (din_valid) begin
              r_toggle <= ~r_toggle;
              if (!r_toggle) r_lo <= din;
            end
            if (!src_loading) r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            r_toggle <= 1'b0;
            if (!r_toggle && r_count == '0 && !r_req) begin
              r_state   <= S_DONE;
              r_loading <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign mem_ds   = r_ds;
  assign mem_req  = r_req;
  assign map_ctrl = r_map;
  assign rom_size = r_rom_size;
  assign rom_mask = r_rom_mask;
  assign ram_mask = r_ram_mask;
  assign loading  = r_loading;
  assign done     = r_done;
  assign fail     = r_fail;

endmodule
`default_nettype wire
